// File: rtl/wb_regfile.sv
// ---------------------------------------------------------------------------
// wb_regfile
//   Writeback register file plus pending-write scoreboard.
//   Commits the WB-stage result into r1..r31 (r0 reads zero), serves two
//   combinational read ports with same-cycle write bypass, and keeps a small
//   in-flight counter per register so decode can stall on RAW hazards.
//
// Ports
//   Clock, Reset         clock, synchronous active-low reset
//   escritaValida/Reg/Dado   writeback result (retires one pending write)
//   emissaoValida/Reg        decode issuing an instruction with destination
//   leituraRegA/B            source indices
//   dadoA/B                  read data (combinational, write-first bypass)
//   pendenteA/B              source still waiting for an in-flight write
//   emissaoAceita            issue accepted (destination counter not full)
//   stall                    decode must hold this cycle
//   erroUnderflow            sticky: retire seen for a register with count 0
// ---------------------------------------------------------------------------

// Per-register in-flight counter. A retire only decrements a non-zero count;
// issue and retire together cancel.
module wb_sbCell #(
  parameter int CW   = 2,
  parameter int CMAX = 3
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          inc,
  input  logic          retire,
  output logic [CW-1:0] cnt
);
  logic dec;
  assign dec = retire & (cnt != '0);

  always_ff @(posedge Clock) begin
    if (!Reset)             cnt <= '0;
    else if (inc & ~dec)    cnt <= cnt + 1'b1;
    else if (dec & ~inc)    cnt <= cnt - 1'b1;
  end
endmodule

module wb_regfile #(
  parameter int NREG = 32,
  parameter int LARG = 32,
  parameter int CMAX = 3
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic                    escritaValida,
  input  logic [$clog2(NREG)-1:0] escritaReg,
  input  logic [LARG-1:0]         escritaDado,
  input  logic                    emissaoValida,
  input  logic [$clog2(NREG)-1:0] emissaoReg,
  input  logic [$clog2(NREG)-1:0] leituraRegA,
  input  logic [$clog2(NREG)-1:0] leituraRegB,
  output logic [LARG-1:0]         dadoA,
  output logic [LARG-1:0]         dadoB,
  output logic                    pendenteA,
  output logic                    pendenteB,
  output logic                    emissaoAceita,
  output logic                    stall,
  output logic                    erroUnderflow
);
  localparam int IW = $clog2(NREG);
  localparam int CW = $clog2(CMAX + 1);

  logic [LARG-1:0]          regs [1:NREG-1];
  logic [NREG-1:0][CW-1:0]  cnt;

  // ---------------- storage ----------------
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      for (int r = 1; r < NREG; r++) regs[r] <= '0;
    end else if (escritaValida && (escritaReg != '0)) begin
      regs[escritaReg] <= escritaDado;
    end
  end

  // Write-first read: an in-cycle writeback to the same register wins.
  always_comb begin
    dadoA = '0;
    if (leituraRegA != '0)
      dadoA = (escritaValida && (escritaReg == leituraRegA)) ? escritaDado : regs[leituraRegA];
  end

  always_comb begin
    dadoB = '0;
    if (leituraRegB != '0)
      dadoB = (escritaValida && (escritaReg == leituraRegB)) ? escritaDado : regs[leituraRegB];
  end

  // ---------------- scoreboard ----------------
  assign cnt[0] = '0;  // r0 is never pending

  for (genvar r = 1; r < NREG; r++) begin : gSb
    logic incR, retR;
    assign incR = emissaoValida & emissaoAceita & (emissaoReg == IW'(r));
    assign retR = escritaValida & (escritaReg == IW'(r));
    wb_sbCell #(.CW(CW), .CMAX(CMAX)) uCell (
      .Clock  (Clock),
      .Reset  (Reset),
      .inc    (incR),
      .retire (retR),
      .cnt    (cnt[r])
    );
  end

  // A full counter can still accept when a retire of the same register frees
  // a slot in this very cycle.
  logic retEmissao;
  assign retEmissao    = escritaValida & (escritaReg == emissaoReg);
  assign emissaoAceita = (emissaoReg == '0) |
                         ~((cnt[emissaoReg] == CW'(CMAX)) & ~retEmissao);

  // The last outstanding write retiring now is covered by the bypass. Issues
  // in this cycle only show up in the count next cycle.
  assign pendenteA = (leituraRegA != '0) & (cnt[leituraRegA] != '0) &
                     ~((cnt[leituraRegA] == CW'(1)) & escritaValida & (escritaReg == leituraRegA));
  assign pendenteB = (leituraRegB != '0) & (cnt[leituraRegB] != '0) &
                     ~((cnt[leituraRegB] == CW'(1)) & escritaValida & (escritaReg == leituraRegB));

  assign stall = pendenteA | pendenteB | (emissaoValida & ~emissaoAceita);

  // Data is still written on underflow; the flag records the protocol error.
  always_ff @(posedge Clock) begin
    if (!Reset)
      erroUnderflow <= 1'b0;
    else if (escritaValida && (escritaReg != '0) && (cnt[escritaReg] == '0))
      erroUnderflow <= 1'b1;
  end
endmodule

// File: tb/tb_wb_regfile.sv
module tb_wb_regfile;
  logic        Clock = 1'b0;
  logic        Reset;
  logic        escritaValida;
  logic [4:0]  escritaReg;
  logic [31:0] escritaDado;
  logic        emissaoValida;
  logic [4:0]  emissaoReg;
  logic [4:0]  leituraRegA, leituraRegB;
  logic [31:0] dadoA, dadoB;
  logic        pendenteA, pendenteB, emissaoAceita, stall, erroUnderflow;

  int nVec = 0;
  int nErr = 0;

  // reference state for the random phase
  logic [31:0] mRegs [32];
  int          mCnt  [32];
  logic        mErr;

  wb_regfile #(.NREG(32), .LARG(32), .CMAX(3)) dut (
    .Clock(Clock), .Reset(Reset),
    .escritaValida(escritaValida), .escritaReg(escritaReg), .escritaDado(escritaDado),
    .emissaoValida(emissaoValida), .emissaoReg(emissaoReg),
    .leituraRegA(leituraRegA), .leituraRegB(leituraRegB),
    .dadoA(dadoA), .dadoB(dadoB), .pendenteA(pendenteA), .pendenteB(pendenteB),
    .emissaoAceita(emissaoAceita), .stall(stall), .erroUnderflow(erroUnderflow)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nVec++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic idle();
    escritaValida = 1'b0; escritaReg = '0; escritaDado = '0;
    emissaoValida = 1'b0; emissaoReg = '0;
  endtask

  // advance one edge, then let inputs be driven and outputs settle mid-cycle
  task automatic tick();
    @(posedge Clock); #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic wr(input logic [4:0] r, input logic [31:0] d);
    escritaValida = 1'b1; escritaReg = r; escritaDado = d;
  endtask

  task automatic iss(input logic [4:0] r);
    emissaoValida = 1'b1; emissaoReg = r;
  endtask

  initial begin
    Reset = 1'b0; idle(); leituraRegA = '0; leituraRegB = '0;
    tick(); Reset = 1'b1;

    // ---- reset state ----
    leituraRegA = 5; leituraRegB = 9; settle();
    chk("rst_dadoA", dadoA, 0);
    chk("rst_pendA", pendenteA, 0);
    chk("rst_pendB", pendenteB, 0);
    chk("rst_aceita", emissaoAceita, 1);
    chk("rst_stall", stall, 0);
    chk("rst_erro", erroUnderflow, 0);

    // ---- write, then reset mid-operation ----
    wr(5, 32'h0000_1234); iss(6); tick(); idle(); settle();
    chk("wr5_store", dadoA, 32'h0000_1234);
    Reset = 1'b0; wr(5, 32'hFFFF_FFFF); iss(8); tick(); Reset = 1'b1; idle();
    leituraRegA = 5; leituraRegB = 6; settle();
    chk("rst2_dadoA", dadoA, 0);
    chk("rst2_pendB", pendenteB, 0);
    leituraRegB = 8; settle();
    chk("rst2_pendB8", pendenteB, 0);
    chk("rst2_stall", stall, 0);

    // ---- write / bypass ----
    wr(7, 32'hDEADBEEF); leituraRegA = 7; settle();
    chk("byp_r7", dadoA, 32'hDEADBEEF);
    tick(); idle(); settle();
    chk("store_r7", dadoA, 32'hDEADBEEF);
    wr(0, 32'hDEADBEEF); leituraRegA = 0; leituraRegB = 7; settle();
    chk("byp_r0", dadoA, 0);
    chk("rdB_r7", dadoB, 32'hDEADBEEF);
    tick(); idle(); settle();
    chk("store_r0", dadoA, 0);
    chk("r0_noUnder", erroUnderflow, 1);  // r0 write ignored, but r7 write above underflowed
    Reset = 1'b0; tick(); Reset = 1'b1; settle();
    chk("erro_clr", erroUnderflow, 0);

    // ---- RAW stall ----
    leituraRegA = 3; leituraRegB = 0; iss(3); settle();
    chk("sameCyc_pendA", pendenteA, 0);
    tick(); idle(); settle();
    chk("raw_pendA", pendenteA, 1);
    chk("raw_stall", stall, 1);
    wr(3, 32'h0000_0011); settle();
    chk("ret_pendA", pendenteA, 0);
    chk("ret_dadoA", dadoA, 32'h11);
    chk("ret_stall", stall, 0);
    tick(); idle(); settle();
    chk("ret_cnt0", pendenteA, 0);
    chk("ret_noUnder", erroUnderflow, 0);

    // ---- saturation ----
    leituraRegA = 0; leituraRegB = 9;
    for (int i = 0; i < 3; i++) begin
      iss(9); settle(); chk($sformatf("sat_acc%0d", i), emissaoAceita, 1); tick();
    end
    idle(); iss(9); settle();
    chk("sat_full_acc", emissaoAceita, 0);
    chk("sat_full_stall", stall, 1);
    chk("sat_pendB", pendenteB, 1);
    tick();
    leituraRegB = 0; iss(9); wr(9, 32'h99); settle();
    chk("sat_ret_acc", emissaoAceita, 1);
    chk("sat_ret_stall", stall, 0);
    tick(); idle(); iss(9); settle();
    chk("sat_still3", emissaoAceita, 0);
    idle();
    for (int i = 0; i < 3; i++) begin wr(9, 32'h90 + i); tick(); end
    idle(); leituraRegB = 9; settle();
    chk("sat_drain_pend", pendenteB, 0);
    chk("sat_drain_dado", dadoB, 32'h92);
    chk("sat_noUnder", erroUnderflow, 0);

    // ---- underflow ----
    leituraRegA = 12; wr(12, 32'h5); tick(); idle(); settle();
    chk("und_dado", dadoA, 32'h5);
    chk("und_flag", erroUnderflow, 1);
    chk("und_pend", pendenteA, 0);
    tick(); tick(); settle();
    chk("und_hold", erroUnderflow, 1);
    Reset = 1'b0; tick(); Reset = 1'b1; settle();
    chk("und_clr", erroUnderflow, 0);
    chk("und_rstDado", dadoA, 0);

    // ---- random against reference model (registers 0..7 to force hazards) ----
    for (int r = 0; r < 32; r++) begin mRegs[r] = '0; mCnt[r] = 0; end
    mErr = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      logic        ev, iv, rstNow, acc;
      logic [4:0]  er, ir, ra, rb;
      logic [31:0] ed, eA, eB;
      logic        pA, pB;
      ev = ($urandom_range(0, 2) == 0); er = 5'($urandom_range(0, 7)); ed = $urandom;
      iv = ($urandom_range(0, 1) == 0); ir = 5'($urandom_range(0, 7));
      ra = 5'($urandom_range(0, 7));    rb = 5'($urandom_range(0, 7));
      rstNow = ($urandom_range(0, 99) == 0);
      escritaValida = ev; escritaReg = er; escritaDado = ed;
      emissaoValida = iv; emissaoReg = ir; leituraRegA = ra; leituraRegB = rb;
      Reset = ~rstNow;
      eA = (ra == 0) ? 32'h0 : ((ev && er == ra) ? ed : mRegs[ra]);
      eB = (rb == 0) ? 32'h0 : ((ev && er == rb) ? ed : mRegs[rb]);
      pA = (ra != 0) && (mCnt[ra] != 0) && !(mCnt[ra] == 1 && ev && er == ra);
      pB = (rb != 0) && (mCnt[rb] != 0) && !(mCnt[rb] == 1 && ev && er == rb);
      acc = (ir == 0) || !(mCnt[ir] == 3 && !(ev && er == ir));
      settle();
      chk($sformatf("rnd%0d dadoA ev=%0d er=%0d iv=%0d ir=%0d ra=%0d rb=%0d", c, ev, er, iv, ir, ra, rb), dadoA, eA);
      chk($sformatf("rnd%0d dadoB", c), dadoB, eB);
      chk($sformatf("rnd%0d pendA ra=%0d cnt=%0d", c, ra, mCnt[ra]), pendenteA, pA);
      chk($sformatf("rnd%0d pendB rb=%0d cnt=%0d", c, rb, mCnt[rb]), pendenteB, pB);
      chk($sformatf("rnd%0d aceita ir=%0d cnt=%0d", c, ir, mCnt[ir]), emissaoAceita, acc);
      chk($sformatf("rnd%0d stall", c), stall, pA | pB | (iv & ~acc));
      chk($sformatf("rnd%0d erro", c), erroUnderflow, mErr);
      // model update at the coming edge
      if (rstNow) begin
        for (int r = 0; r < 32; r++) begin mRegs[r] = '0; mCnt[r] = 0; end
        mErr = 1'b0;
      end else begin
        logic doInc, doDec;
        doInc = iv && acc && (ir != 0);
        doDec = ev && (er != 0) && (mCnt[er] != 0);
        if (ev && er != 0 && mCnt[er] == 0) mErr = 1'b1;
        if (ev && er != 0) mRegs[er] = ed;
        if (doInc && !(doDec && er == ir)) mCnt[ir] = mCnt[ir] + 1;
        if (doDec && !(doInc && er == ir)) mCnt[er] = mCnt[er] - 1;
      end
      tick();
    end
    Reset = 1'b1; idle();

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
